conv_mac_accumulator: RTL

//  Consumer stage directly downstream of the convolution loop-nest iterator.
//  - Takes per-cycle sum/save strobes and loop indices, plus pixel/weight bytes read from BRAMs

---
 rtl/conv_mac_accumulator_pkg.sv | 22 ++
 rtl/conv_requant.sv | 37 +++
 rtl/conv_mac_accumulator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_accumulator_pkg.sv
// rtl/conv_mac_accumulator_pkg.sv - shared constants and flush FSM encodings for the conv MAC accumulator
//   BYTE          : pixel / weight / result width
//   ACC_W_DEF     : default accumulator width
//   CLAMP_MIN/MAX : signed 8-bit saturation bounds of the written result
//   DRAIN_CYCLES  : cycles the flush FSM waits for in-flight MAC terms
//   conv_state_t  : flush FSM states IDLE / RUN / DRAIN / DONE
package conv_mac_accumulator_pkg;

   localparam int BYTE         = 8;
   localparam int ACC_W_DEF    = 32;
   localparam int CLAMP_MIN    = -128;
   localparam int CLAMP_MAX    = 127;
   localparam int DRAIN_CYCLES = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_t;

endpackage

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - combinational requantiser: arithmetic shift, optional ReLU, clamp to 8 bits
//   i_acc  in  ACC_W  signed accumulator of a completed window
//   o_data out 8      signed saturated result
// Build option: CONV_RELU_EN forces negative results to zero before the clamp.
module conv_requant
   import conv_mac_accumulator_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int OUT_SHIFT = 8
) (
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [BYTE-1:0]  o_data
);

   localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'(CLAMP_MAX);
   localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'(CLAMP_MIN);

   logic signed [ACC_W-1:0] w_shifted;

   always_comb begin
      w_shifted = i_acc >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
      if (w_shifted < 0) begin
         w_shifted = '0;
      end
`else
`endif
      if (w_shifted > L_MAX) begin
         o_data = 8'sh7f;
      end else if (w_shifted < L_MIN) begin
         o_data = 8'sh80;
      end else begin
         o_data = w_shifted[BYTE-1:0];
      end
   end

endmodule

// File: rtl/conv_mac_accumulator.sv
// rtl/conv_mac_accumulator.sv - per-window signed MAC, bias seed, requantise and output-memory write
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   en_sum, en_save     : MAC-term / new-window strobes from the loop-nest iterator
//   fin                 : iterator finished (level); flushes the open window
//   i, j, k             : channel / row / col of the window named by en_save
//   img_data, wt_data   : signed BRAM read data, valid the cycle after en_sum
//   bias                : signed channel bias, sampled with en_save
//   out_we/addr/data    : one-cycle write of a completed window
//   done                : sticky, every result written
// Build option: CONV_RELU_EN writes negative results as zero.
module conv_mac_accumulator
   import conv_mac_accumulator_pkg::*;
#(
   parameter int CONV_DIM_OUT = 32,
   parameter int CONV_OUT_CH  = 32,
   parameter int BIAS_SHIFT   = 0,
   parameter int OUT_SHIFT    = 8,
   parameter int ACC_W        = ACC_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en_sum,
   input  logic                   en_save,
   input  logic                   fin,
   input  logic [7:0]             i,
   input  logic [7:0]             j,
   input  logic [7:0]             k,
   input  logic signed [BYTE-1:0] img_data,
   input  logic signed [BYTE-1:0] wt_data,
   input  logic signed [BYTE-1:0] bias,
   output logic                   out_we,
   output logic [15:0]            out_addr,
   output logic signed [BYTE-1:0] out_data,
   output logic                   done
);

   localparam int L_PLANE = CONV_DIM_OUT * CONV_DIM_OUT;

   generate
      if (CONV_OUT_CH * L_PLANE > 65536) begin : g_addr_range_chk
         $error("conv_mac_accumulator: output map does not fit a 16-bit address");
      end
   endgenerate

   // flush FSM
   conv_state_t r_state, w_state_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic        w_accept;
   logic        w_flush;

   // S1 / S2 / S3 pipeline
   logic                   r1_sum, r1_save;
   logic [15:0]            r1_addr;
   logic signed [BYTE-1:0] r1_bias;
   logic                   r2_sum, r2_save;
   logic [15:0]            r2_addr;
   logic signed [BYTE-1:0] r2_bias;
   logic signed [15:0]     r2_prod;
   logic signed [ACC_W-1:0] r_acc;
   logic [15:0]            r_addr;
   logic                   r_open;

   // hand-off and output stage
   logic                   r_ho_valid;
   logic signed [ACC_W-1:0] r_ho_acc;
   logic [15:0]            r_ho_addr;
   logic                   r_out_we;
   logic [15:0]            r_out_addr;
   logic signed [BYTE-1:0] r_out_data;
   logic                   r_done;

   logic [15:0]             w_addr;
   logic signed [15:0]      w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_seed;
   logic signed [ACC_W-1:0] w_term;
   logic signed [BYTE-1:0]  w_req;

   // Truncation to 16 bits is exact: the elaboration check keeps every legal index in range.
   assign w_addr     = 16'(i) * 16'(L_PLANE) + 16'(j) * 16'(CONV_DIM_OUT) + 16'(k);
   assign w_prod     = img_data * wt_data;
   assign w_prod_ext = $signed({{(ACC_W-16){r2_prod[15]}}, r2_prod});
   assign w_seed     = $signed({{(ACC_W-BYTE){r2_bias[BYTE-1]}}, r2_bias}) <<< BIAS_SHIFT;
   assign w_term     = r2_sum ? w_prod_ext : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_accept = 1'b1;
            if (en_save) begin
               w_state_nxt = ST_RUN;
            end else if (fin) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_RUN: begin
            // Strobes issued alongside fin are still taken; the drain covers them.
            w_accept = 1'b1;
            if (fin) begin
               w_state_nxt = ST_DRAIN;
               w_cnt_nxt   = '0;
            end
         end
         ST_DRAIN: begin
            if (r_cnt == 2'(DRAIN_CYCLES - 1)) begin
               w_flush     = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_DONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1_sum  <= 1'b0;
         r1_save <= 1'b0;
         r1_addr <= '0;
         r1_bias <= '0;
         r2_sum  <= 1'b0;
         r2_save <= 1'b0;
         r2_addr <= '0;
         r2_bias <= '0;
         r2_prod <= '0;
      end else begin
         r1_sum  <= en_sum & w_accept;
         r1_save <= en_save & w_accept;
         r1_addr <= w_addr;
         r1_bias <= bias;
         // BRAM data belonging to the S1 strobe arrives this cycle.
         r2_sum  <= r1_sum;
         r2_save <= r1_save;
         r2_addr <= r1_addr;
         r2_bias <= r1_bias;
         r2_prod <= w_prod;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc      <= '0;
         r_addr     <= '0;
         r_open     <= 1'b0;
         r_ho_valid <= 1'b0;
         r_ho_acc   <= '0;
         r_ho_addr  <= '0;
      end else begin
         r_ho_valid <= r_open & (r2_save | w_flush);
         if (r_open & (r2_save | w_flush)) begin
            r_ho_acc  <= r_acc;
            r_ho_addr <= r_addr;
         end
         if (r2_save) begin
            // The coincident term belongs to the new window, not the one handed off.
            r_acc  <= w_seed + w_term;
            r_addr <= r2_addr;
            r_open <= 1'b1;
         end else begin
            if (r2_sum) begin
               r_acc <= r_acc + w_prod_ext;
            end
            if (w_flush) begin
               r_open <= 1'b0;
            end
         end
      end
   end

   conv_requant #(
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_requant (
      .i_acc  (r_ho_acc),
      .o_data (w_req)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_we   <= 1'b0;
         r_out_addr <= '0;
         r_out_data <= '0;
         r_done     <= 1'b0;
      end else begin
         r_out_we <= r_ho_valid;
         if (r_ho_valid) begin
            r_out_addr <= r_ho_addr;
            r_out_data <= w_req;
         end
         // Rises together with the flush write, so done implies everything landed.
         if (r_state == ST_DONE) begin
            r_done <= 1'b1;
         end
      end
   end

   assign out_we   = r_out_we;
   assign out_addr = r_out_addr;
   assign out_data = r_out_data;
   assign done     = r_done;

endmodule
